// File: rtl/trace_pkg.sv
// Shared types for the issue trace buffer: FSM state encoding and the trace entry layout.
package trace_pkg;

  localparam int unsigned TsWidth  = 16;
  localparam int unsigned DefLanes = 2;
  localparam int unsigned DefXlen  = 32;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StArmed     = 2'd1,
    StTriggered = 2'd2,
    StDone      = 2'd3
  } trace_state_t;

  // Field order of one entry at the default geometry; the buffer keeps each field in its own array.
  typedef struct packed {
    logic [DefLanes-1:0]         mask;
    logic [DefLanes*DefXlen-1:0] ins;
    logic [DefLanes*DefXlen-1:0] result;
    logic [TsWidth-1:0]          ts;
  } trace_entry_t;

endpackage

// File: rtl/trace_trig_cmp.sv
// Per-lane masked trigger compare: hit[l] when lane l's instruction matches under the mask.
module trace_trig_cmp #(
  parameter int unsigned LANES = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic [LANES*XLEN-1:0] ins,
  input  logic [XLEN-1:0]       match,
  input  logic [XLEN-1:0]       mask,
  output logic [LANES-1:0]      hit
);

  always_comb begin
    hit = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      hit[l] = (ins[l*XLEN +: XLEN] & mask) == (match & mask);
    end
  end

endmodule

// File: rtl/issue_trace_buf.sv
// Issue-lane trace buffer with arm/trigger/post-capture FSM and show-ahead read-out.
// Optional macro TRACE_TIMESTAMP_EN adds a 16-bit cycle timestamp to every entry.
module issue_trace_buf
  import trace_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_pin,
  input  logic                       arm,
  input  logic                       disarm,
  input  logic [XLEN-1:0]            trig_match,
  input  logic [XLEN-1:0]            trig_mask,
  input  logic [$clog2(DEPTH):0]     post_count,
  input  logic [LANES-1:0]           lane_valid,
  input  logic [LANES-1:0]           lane_freeze,
  input  logic [LANES*XLEN-1:0]      lane_ins,
  input  logic [LANES*XLEN-1:0]      lane_result,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [LANES-1:0]           rd_mask,
  output logic [LANES*XLEN-1:0]      rd_ins,
  output logic [LANES*XLEN-1:0]      rd_result,
  output logic [TsWidth-1:0]         rd_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

  trace_state_t   state_q, state_d;
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  remaining_q, remaining_d;
  logic           overflow_q;

  logic [LANES-1:0]      cap_mask;
  logic [LANES-1:0]      hit;
  logic                  capturing, trig, do_pop, do_clear;
  logic [LANES*XLEN-1:0] wr_ins, wr_result;

  logic [LANES-1:0]      mask_mem   [DEPTH];
  logic [LANES*XLEN-1:0] ins_mem    [DEPTH];
  logic [LANES*XLEN-1:0] result_mem [DEPTH];

  trace_trig_cmp #(
    .LANES (LANES),
    .XLEN  (XLEN)
  ) u_trig_cmp (
    .ins   (lane_ins),
    .match (trig_match),
    .mask  (trig_mask),
    .hit   (hit)
  );

  always_comb begin
    cap_mask  = lane_valid & ~lane_freeze;
    capturing = ((state_q == StArmed) || (state_q == StTriggered)) && (|cap_mask);
    trig      = (state_q == StArmed) && capturing && (|(hit & cap_mask));
    rd_valid  = (count_q != '0) && ((state_q == StIdle) || (state_q == StDone));
    do_pop    = rd_en && rd_valid;
    do_clear  = !disarm && arm && ((state_q == StIdle) || (state_q == StDone));
  end

  // Lanes that did not issue are stored as zero so read-out never shows stale lane data.
  always_comb begin
    wr_ins    = '0;
    wr_result = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (cap_mask[l]) begin
        wr_ins[l*XLEN +: XLEN]    = lane_ins[l*XLEN +: XLEN];
        wr_result[l*XLEN +: XLEN] = lane_result[l*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (disarm) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (arm) state_d = StArmed;
        end
        StArmed: begin
          if (trig) begin
            remaining_d = post_count;
            state_d     = (post_count == '0) ? StDone : StTriggered;
          end
        end
        StTriggered: begin
          if (capturing) begin
            remaining_d = remaining_q - CntOne;
            if (remaining_q == CntOne) state_d = StDone;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_pin) begin
    if (!rst_pin) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      if (do_clear) begin
        wptr_q     <= '0;
        rptr_q     <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (capturing) begin
        wptr_q <= wptr_q + PtrOne;
        // A full buffer drops its oldest entry to make room.
        if (count_q == CntFull) begin
          rptr_q     <= rptr_q + PtrOne;
          overflow_q <= 1'b1;
        end else begin
          count_q <= count_q + CntOne;
        end
      end else if (do_pop) begin
        rptr_q  <= rptr_q + PtrOne;
        count_q <= count_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capturing) begin
      mask_mem[wptr_q]   <= cap_mask;
      ins_mem[wptr_q]    <= wr_ins;
      result_mem[wptr_q] <= wr_result;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TsWidth-1:0] ts_q;
  logic [TsWidth-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_pin) begin
    if (!rst_pin) begin
      ts_q <= '0;
    end else if (do_clear) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TsWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (capturing) ts_mem[wptr_q] <= ts_q;
  end

  assign rd_ts = ts_mem[rptr_q];
`else
  assign rd_ts = '0;
`endif

  assign rd_mask   = mask_mem[rptr_q];
  assign rd_ins    = ins_mem[rptr_q];
  assign rd_result = result_mem[rptr_q];
  assign count     = count_q;
  assign state     = state_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_issue_trace_buf.sv
// Bench for issue_trace_buf: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic. Honours TRACE_TIMESTAMP_EN like the design.
module tb_issue_trace_buf;

  localparam int LANES = 2;
  localparam int DEPTH = 16;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        rst_pin = 1'b0;
  logic        arm = 1'b0, disarm = 1'b0, rd_en = 1'b0;
  logic [31:0] trig_match = '0, trig_mask = '0;
  logic [4:0]  post_count = '0;
  logic [1:0]  lane_valid = '0, lane_freeze = '0;
  logic [63:0] lane_ins = '0, lane_result = '0;
  logic        rd_valid;
  logic [1:0]  rd_mask;
  logic [63:0] rd_ins, rd_result;
  logic [15:0] rd_ts;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  issue_trace_buf #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk         (clk),
    .rst_pin     (rst_pin),
    .arm         (arm),
    .disarm      (disarm),
    .trig_match  (trig_match),
    .trig_mask   (trig_mask),
    .post_count  (post_count),
    .lane_valid  (lane_valid),
    .lane_freeze (lane_freeze),
    .lane_ins    (lane_ins),
    .lane_result (lane_result),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_mask     (rd_mask),
    .rd_ins      (rd_ins),
    .rd_result   (rd_result),
    .rd_ts       (rd_ts),
    .count       (count),
    .state       (state),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a plain queue of entries, oldest at index 0.
  typedef struct {
    logic [1:0]  mask;
    logic [63:0] ins;
    logic [63:0] res;
    logic [15:0] ts;
  } ent_t;

  ent_t        q[$];
  int          m_state = 0;
  int          m_rem = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_ts = '0;

  always @(posedge clk or negedge rst_pin) begin
    if (!rst_pin) begin
      q.delete();
      m_state = 0;
      m_rem   = 0;
      m_ovf   = 1'b0;
      m_ts    = '0;
    end else begin
      logic [1:0] cm;
      bit   cap, hit, clr, pop;
      int   st;
      ent_t e;
      st  = m_state;
      cm  = lane_valid & ~lane_freeze;
      cap = (st == 1 || st == 2) && cm != 2'b00;
      hit = 1'b0;
      e.mask = cm;
      e.ins  = '0;
      e.res  = '0;
      e.ts   = m_ts;
      for (int l = 0; l < LANES; l++) begin
        if (cm[l]) begin
          e.ins[l*32 +: 32] = lane_ins[l*32 +: 32];
          e.res[l*32 +: 32] = lane_result[l*32 +: 32];
          if ((lane_ins[l*32 +: 32] & trig_mask) == (trig_match & trig_mask)) hit = 1'b1;
        end
      end
      pop = rd_en && q.size() != 0 && (st == 0 || st == 3);
      clr = !disarm && arm && (st == 0 || st == 3);
      if (cap) begin
        q.push_back(e);
        if (q.size() > DEPTH) begin
          void'(q.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (pop) void'(q.pop_front());
      if (disarm) m_state = 0;
      else if (clr) m_state = 1;
      else if (st == 1 && cap && hit) begin
        m_rem   = int'(post_count);
        m_state = (post_count == 0) ? 3 : 2;
      end else if (st == 2 && cap) begin
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
      if (clr) begin
        q.delete();
        m_ovf = 1'b0;
        m_ts  = '0;
      end else begin
        m_ts = m_ts + 16'd1;
      end
    end
  end

  // Compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      bit exp_valid;
      exp_valid = q.size() != 0 && (m_state == 0 || m_state == 3);
      chk("state", 64'(state), 64'(m_state));
      chk("count", 64'(count), 64'(q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("rd_valid", 64'(rd_valid), 64'(exp_valid));
      if (exp_valid) begin
        chk("rd_mask", 64'(rd_mask), 64'(q[0].mask));
        chk("rd_ins", rd_ins, q[0].ins);
        chk("rd_result", rd_result, q[0].res);
`ifdef TRACE_TIMESTAMP_EN
        chk("rd_ts", 64'(rd_ts), 64'(q[0].ts));
`else
        chk("rd_ts", 64'(rd_ts), 64'h0);
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    arm = 1'b0; disarm = 1'b0; rd_en = 1'b0;
    lane_valid = '0; lane_freeze = '0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  initial begin
    // Reset
    cyc(3);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    rst_pin = 1'b1;
    chk_en  = 1'b1;
    cyc(2);

    // Trigger on first issue, three post entries, then read out with rd_en held five cycles
    trig_match = 32'h0010_0093; trig_mask = 32'hFFFF_FFFF; post_count = 5'd3;
    do_arm();
    lane_valid = 2'b01;
    lane_ins = {32'h0, 32'h0010_0093};
    lane_result = {32'h0, 32'h0000_0042};
    cyc(4);
    lane_valid = '0;
    chk("basic_state_done", 64'(state), 64'd3);
    chk("basic_count4", 64'(count), 64'd4);
    chk("basic_first_ins", 64'(rd_ins[31:0]), 64'h0010_0093);
`ifdef TRACE_TIMESTAMP_EN
    chk("basic_first_ts", 64'(rd_ts), 64'd0);
`endif
    rd_en = 1'b1;
    cyc(5);
    rd_en = 1'b0;
    chk("readout_count0", 64'(count), 64'd0);
    chk("readout_rd_valid0", 64'(rd_valid), 64'd0);

    // No trigger, 20 captures into a 16-deep buffer
    trig_match = 32'hFFFF_FFFF;
    do_arm();
    for (int i = 1; i <= 20; i++) begin
      lane_valid = 2'b01;
      lane_ins = {32'h0, 32'(i)};
      cyc(1);
    end
    lane_valid = '0;
    disarm = 1'b1;
    cyc(1);
    disarm = 1'b0;
    chk("wrap_count16", 64'(count), 64'd16);
    chk("wrap_overflow", 64'(overflow), 64'd1);
    chk("wrap_oldest_is_5", 64'(rd_ins[31:0]), 64'd5);

    // Frozen lane masked off; trigger with post_count 0 ends capture at once
    trig_match = 32'h0000_AAAA; post_count = 5'd0;
    do_arm();
    lane_valid = 2'b11; lane_freeze = 2'b10;
    lane_ins = {32'h0000_BBBB, 32'h0000_AAAA};
    lane_result = {32'h0000_DDDD, 32'h0000_CCCC};
    cyc(1);
    chk("freeze_state_done", 64'(state), 64'd3);
    chk("freeze_count1", 64'(count), 64'd1);
    chk("freeze_mask", 64'(rd_mask), 64'd1);
    chk("freeze_lane1_ins", 64'(rd_ins[63:32]), 64'd0);
    chk("freeze_lane1_res", 64'(rd_result[63:32]), 64'd0);
    chk("freeze_lane0_res", 64'(rd_result[31:0]), 64'h0000_CCCC);
    lane_freeze = 2'b00;
    cyc(3);
    chk("done_no_capture", 64'(count), 64'd1);

    // Asynchronous reset in the middle of post-trigger capture
    trig_match = 32'h0000_1234; post_count = 5'd10;
    do_arm();
    lane_valid = 2'b01;
    lane_ins = {32'h0, 32'h0000_1234};
    cyc(3);
    chk("pre_reset_triggered", 64'(state), 64'd2);
    #2;
    rst_pin = 1'b0;
    #1;
    chk("async_state", 64'(state), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_rd_valid", 64'(rd_valid), 64'd0);
    cyc(1);
    idle_inputs();
    rst_pin = 1'b1;
    cyc(1);

    // Randomized traffic
    trig_match = 32'h0010_0093;
    for (int n = 0; n < 4000; n++) begin
      arm    = ($urandom % 16) == 0;
      disarm = ($urandom % 48) == 0;
      rd_en  = $urandom % 2;
      lane_valid  = 2'($urandom);
      lane_freeze = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
      for (int l = 0; l < LANES; l++) begin
        lane_ins[l*32 +: 32]    = ($urandom % 6 == 0) ? 32'h0010_0093 : $urandom;
        lane_result[l*32 +: 32] = $urandom;
      end
      trig_mask  = ($urandom % 2) ? 32'hFFFF_FFFF : 32'h0000_007F;
      post_count = 5'($urandom_range(0, DEPTH));
      cyc(1);
    end
    idle_inputs();
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
